// File: rtl/german_home_system_param.sv
// German-style coherence model: one home directory plus NUM_CLIENTS caches,
// advancing by exactly one externally selected guarded rule per clock.
module german_home_system_param #(
    parameter int NUM_CLIENTS = 13,
    parameter int CLIENT_W    = $clog2(NUM_CLIENTS),
    parameter int COUNT_W     = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [CLIENT_W+3:0]        io_en_a,
    output logic                       io_fired,
    output logic [COUNT_W-1:0]         io_step_count,
    output logic                       io_err_coherence,
    output logic                       io_idle,
    output logic [2*NUM_CLIENTS-1:0]   io_cache_state
);

    localparam logic [1:0] C_I   = 2'd0;
    localparam logic [1:0] C_S   = 2'd1;
    localparam logic [1:0] C_E   = 2'd2;
    localparam logic [1:0] M_EMPTY = 2'd0;
    localparam logic [1:0] M_REQS  = 2'd1;
    localparam logic [1:0] M_REQE  = 2'd2;
    localparam logic [1:0] M_INV   = 2'd1;
    localparam logic [1:0] M_GNTS  = 2'd2;
    localparam logic [1:0] M_GNTE  = 2'd3;
    localparam logic [CLIENT_W:0] NUM_CLIENTS_V = (CLIENT_W+1)'(NUM_CLIENTS);

    logic [NUM_CLIENTS-1:0][1:0] cache_q, cache_d;
    logic [NUM_CLIENTS-1:0][1:0] ch1_q, ch1_d;
    logic [NUM_CLIENTS-1:0][1:0] ch2_q, ch2_d;
    logic [NUM_CLIENTS-1:0]      ch3_q, ch3_d;
    logic [NUM_CLIENTS-1:0]      sharer_q, sharer_d;
    logic [NUM_CLIENTS-1:0]      inv_q, inv_d;
    logic [1:0]                  home_cmd_q, home_cmd_d;
    logic [CLIENT_W-1:0]         home_client_q, home_client_d;
    logic                        excl_q, excl_d;
    logic                        fired_q;
    logic [COUNT_W-1:0]          step_q;
    logic                        err_q;

    logic [CLIENT_W-1:0] sel_c;
    logic [3:0]          sel_k;
    logic                sel_ok;
    logic                fire;
    logic [6:0]          n_e, n_s;
    logic                viol;

    assign sel_c  = io_en_a[CLIENT_W+3:4];
    assign sel_k  = io_en_a[3:0];
    assign sel_ok = ({1'b0, sel_c} < NUM_CLIENTS_V);

    // Guards read only pre-edge state; a false guard leaves every _d equal to _q.
    always_comb begin
        cache_d       = cache_q;
        ch1_d         = ch1_q;
        ch2_d         = ch2_q;
        ch3_d         = ch3_q;
        sharer_d      = sharer_q;
        inv_d         = inv_q;
        home_cmd_d    = home_cmd_q;
        home_client_d = home_client_q;
        excl_d        = excl_q;
        fire          = 1'b0;
        if (sel_ok) begin
            case (sel_k)
                4'd0: if (cache_q[sel_c] == C_I && ch1_q[sel_c] == M_EMPTY) begin
                    fire = 1'b1;
                    ch1_d[sel_c] = M_REQS;
                end
                4'd1: if ((cache_q[sel_c] == C_I || cache_q[sel_c] == C_S) &&
                          ch1_q[sel_c] == M_EMPTY) begin
                    fire = 1'b1;
                    ch1_d[sel_c] = M_REQE;
                end
                4'd2: if (home_cmd_q == M_EMPTY && ch1_q[sel_c] != M_EMPTY) begin
                    fire = 1'b1;
                    home_cmd_d    = ch1_q[sel_c];
                    home_client_d = sel_c;
                    ch1_d[sel_c]  = M_EMPTY;
                    inv_d         = sharer_q;
                end
                4'd3: if (ch2_q[sel_c] == M_EMPTY && inv_q[sel_c] &&
                          (home_cmd_q == M_REQE || (home_cmd_q == M_REQS && excl_q))) begin
                    fire = 1'b1;
                    ch2_d[sel_c] = M_INV;
                    inv_d[sel_c] = 1'b0;
                end
                4'd4: if (ch2_q[sel_c] == M_INV && !ch3_q[sel_c]) begin
                    fire = 1'b1;
                    ch2_d[sel_c]   = M_EMPTY;
                    ch3_d[sel_c]   = 1'b1;
                    cache_d[sel_c] = C_I;
                end
                4'd5: if (ch3_q[sel_c] && home_cmd_q != M_EMPTY) begin
                    fire = 1'b1;
                    ch3_d[sel_c]    = 1'b0;
                    sharer_d[sel_c] = 1'b0;
                    excl_d          = 1'b0;
                end
                4'd6: if (home_cmd_q == M_REQS && home_client_q == sel_c && !excl_q &&
                          ch2_q[sel_c] == M_EMPTY) begin
                    fire = 1'b1;
                    ch2_d[sel_c]    = M_GNTS;
                    sharer_d[sel_c] = 1'b1;
                    home_cmd_d      = M_EMPTY;
                end
                4'd7: if (home_cmd_q == M_REQE && home_client_q == sel_c && !excl_q &&
                          ch2_q[sel_c] == M_EMPTY && sharer_q == '0) begin
                    fire = 1'b1;
                    ch2_d[sel_c]    = M_GNTE;
                    sharer_d[sel_c] = 1'b1;
                    excl_d          = 1'b1;
                    home_cmd_d      = M_EMPTY;
                end
                4'd8: if (ch2_q[sel_c] == M_GNTS || ch2_q[sel_c] == M_GNTE) begin
                    fire = 1'b1;
                    cache_d[sel_c] = (ch2_q[sel_c] == M_GNTE) ? C_E : C_S;
                    ch2_d[sel_c]   = M_EMPTY;
                end
                default: ;
            endcase
        end
    end

    // Coherence: at most one E, and an E excludes every S.
    always_comb begin
        n_e = '0;
        n_s = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (cache_q[i] == C_E) n_e = n_e + 7'd1;
            if (cache_q[i] == C_S) n_s = n_s + 7'd1;
        end
        viol = (n_e >= 7'd2) || (n_e >= 7'd1 && n_s >= 7'd1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cache_q       <= '0;
            ch1_q         <= '0;
            ch2_q         <= '0;
            ch3_q         <= '0;
            sharer_q      <= '0;
            inv_q         <= '0;
            home_cmd_q    <= M_EMPTY;
            home_client_q <= '0;
            excl_q        <= 1'b0;
            fired_q       <= 1'b0;
            step_q        <= '0;
            err_q         <= 1'b0;
        end else begin
            cache_q       <= cache_d;
            ch1_q         <= ch1_d;
            ch2_q         <= ch2_d;
            ch3_q         <= ch3_d;
            sharer_q      <= sharer_d;
            inv_q         <= inv_d;
            home_cmd_q    <= home_cmd_d;
            home_client_q <= home_client_d;
            excl_q        <= excl_d;
            fired_q       <= fire;
            if (fire && step_q != '1) step_q <= step_q + COUNT_W'(1);
            err_q         <= err_q | viol;
        end
    end

    assign io_fired         = fired_q;
    assign io_step_count    = step_q;
    assign io_err_coherence = err_q;
    assign io_idle          = (home_cmd_q == M_EMPTY) && (ch1_q == '0) &&
                              (ch2_q == '0) && (ch3_q == '0);
    assign io_cache_state   = cache_q;

endmodule
